// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the select of a 4:1 bit mux through the enabled
// channels, holds each channel for a programmable dwell, samples the mux
// output at the end of each dwell and presents the assembled 4-bit word with
// a one-cycle valid strobe.
// Optional build macro SCAN_CONTINUOUS_EN: rescan back-to-back until stop.
module mux_scan_sequencer #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    en_mask,
  input  logic [DW-1:0] dwell,
  input  logic          mux_out,
  output logic [1:0]    sel,
  output logic [3:0]    sample,
  output logic          sample_valid,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    mask_q;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] cnt;
  logic [3:0]    shadow;
  logic [3:0]    captured;
  logic [2:0]    nxt;
  logic          launch_ok;
  logic [DW-1:0] dwell_eff;
  logic [1:0]    first_sel;

`ifdef SCAN_CONTINUOUS_EN
  logic          stop_pend;
`else
  logic          unused_stop;
  assign unused_stop = stop;
`endif

  // Lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [1:0] lowest_en(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next enabled channel strictly above cur, as {found, index}.
  function automatic logic [2:0] next_en(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(cur) && m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Shadow word with the current channel's sample merged, plus launch terms.
  always_comb begin
    captured      = shadow;
    captured[sel] = mux_out;
    nxt           = next_en(mask_q, sel);
    launch_ok     = (en_mask != 4'd0);
    dwell_eff     = (dwell == '0) ? DW'(1) : dwell;
    first_sel     = lowest_en(en_mask);
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_q       <= 4'd0;
      dwell_q      <= '0;
      cnt          <= '0;
      shadow       <= 4'd0;
      sel          <= 2'd0;
      sample       <= 4'd0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef SCAN_CONTINUOUS_EN
      stop_pend    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sel          <= 2'd0;
          busy         <= 1'b0;
          sample_valid <= 1'b0;
          if (start && launch_ok) begin
            mask_q  <= en_mask;
            dwell_q <= dwell_eff;
            sel     <= first_sel;
            shadow  <= 4'd0;
            cnt     <= DW'(1);
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end

        SCAN: begin
`ifdef SCAN_CONTINUOUS_EN
          if (stop) stop_pend <= 1'b1;
`endif
          if (cnt == dwell_q) begin
            shadow <= captured;
            cnt    <= DW'(1);
            if (nxt[2]) begin
              sel <= nxt[1:0];
            end else begin
              sample       <= captured;
              sample_valid <= 1'b1;
              busy         <= 1'b0;
              sel          <= 2'd0;
              state        <= DONE;
            end
          end else begin
            cnt <= cnt + DW'(1);
          end
        end

        DONE: begin
          sample_valid <= 1'b0;
          state        <= IDLE;
`ifdef SCAN_CONTINUOUS_EN
          // Relaunch straight from DONE unless a stop was seen this pass.
          stop_pend <= 1'b0;
          if (!stop_pend && !stop && launch_ok) begin
            mask_q  <= en_mask;
            dwell_q <= dwell_eff;
            sel     <= first_sel;
            shadow  <= 4'd0;
            cnt     <= DW'(1);
            busy    <= 1'b1;
            state   <= SCAN;
          end
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: cycle-level reference model plus
// directed scans with hand-computed strobe timing and sample words.
module tb_mux_scan_sequencer;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b1;
  logic [3:0]    en_mask = 4'd0;
  logic [DW-1:0] dwell = '0;
  logic [3:0]    in_vec = 4'd0;
  logic          mux_out;
  logic [1:0]    sel;
  logic [3:0]    sample;
  logic          sample_valid;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mux_scan_sequencer #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .en_mask(en_mask), .dwell(dwell), .mux_out(mux_out),
    .sel(sel), .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );

  // The 4:1 mux being scanned.
  assign mux_out = in_vec[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 scanning (k = cycles elapsed), 2 done.
  int         ph = 0;
  int         k = 0;
  int         n = 0;
  int         d = 1;
  int         ch[4];
  logic [3:0] m_mask = 4'd0;
  logic [3:0] m_sample = 4'd0;
  bit         m_stop = 1'b0;

  task automatic m_launch();
    m_mask = en_mask;
    d = (dwell == '0) ? 1 : int'(dwell);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (en_mask[i]) begin
        ch[n] = i;
        n = n + 1;
      end
    end
    k = 0;
    ph = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; k = 0; m_sample = 4'd0; m_stop = 1'b0;
    end else begin
      case (ph)
        0: if (start && en_mask != 4'd0) m_launch();
        1: begin
          if (stop) m_stop = 1'b1;
          k = k + 1;
          if (k == n * d) begin
            ph = 2;
            m_sample = in_vec & m_mask;
          end
        end
        default: begin
          ph = 0;
`ifdef SCAN_CONTINUOUS_EN
          if (!m_stop && !stop && en_mask != 4'd0) m_launch();
`endif
          m_stop = 1'b0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_sel", int'(sel), (ph == 1) ? ch[k / d] : 0);
    chk("model_busy", int'(busy), (ph == 1) ? 1 : 0);
    chk("model_valid", int'(sample_valid), (ph == 2) ? 1 : 0);
    chk("model_sample", int'(sample), int'(m_sample));
  end

  // Directed scan bookkeeping.
  int         vcyc;
  int         vcnt;
  int         bcnt;
  int         v1;
  int         v2;
  logic [3:0] vs;
  logic [1:0] trace [0:15];
  int         exp_full [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int         exp_skip [6] = '{1, 1, 1, 3, 3, 3};

  // Start a scan at edge 0 and observe cycles 1..ncyc.
  task automatic run_scan(input logic [3:0] m, input logic [DW-1:0] dw,
                          input logic [3:0] iv, input bit poke, input int ncyc);
    @(negedge clk); #1;
    en_mask = m; dwell = dw; in_vec = iv; start = 1'b1;
    vcyc = -1; vcnt = 0; bcnt = 0; vs = 4'd0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c <= 15) trace[c] = sel;
      if (busy) bcnt = bcnt + 1;
      if (sample_valid) begin
        vcnt = vcnt + 1;
        vcyc = c;
        vs = sample;
      end
      #1;
      if (c == 1) start = 1'b0;
      if (poke && c == 3) start = 1'b1;
      if (poke && c == 4) start = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_sel", int'(sel), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sample", int'(sample), 0);
    chk("reset_valid", int'(sample_valid), 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full scan, dwell 2.
    run_scan(4'b1111, 4'd2, 4'b1010, 1'b0, 14);
    chk("full_valid_cycle", vcyc, 9);
    chk("full_valid_count", vcnt, 1);
    chk("full_sample", int'(vs), 10);
    chk("full_busy_cycles", bcnt, 8);
    for (int i = 0; i < 8; i++) chk("full_sel_trace", int'(trace[i + 1]), exp_full[i]);

    // Disabled channels skipped, dwell 3.
    run_scan(4'b1010, 4'd3, 4'b1111, 1'b0, 12);
    chk("skip_valid_cycle", vcyc, 7);
    chk("skip_sample", int'(vs), 10);
    for (int i = 0; i < 6; i++) chk("skip_sel_trace", int'(trace[i + 1]), exp_skip[i]);

    // Dwell 0 acts as dwell 1.
    run_scan(4'b1111, 4'd0, 4'b0110, 1'b0, 8);
    chk("dwell0_valid_cycle", vcyc, 5);
    chk("dwell0_sample", int'(vs), 6);

    // Empty mask is ignored.
    run_scan(4'b0000, 4'd2, 4'b1111, 1'b0, 10);
    chk("nomask_valid_count", vcnt, 0);
    chk("nomask_busy_cycles", bcnt, 0);

    // Start re-asserted mid-scan is ignored.
    run_scan(4'b1111, 4'd2, 4'b0101, 1'b1, 20);
    chk("busy_start_count", vcnt, 1);
    chk("busy_start_cycle", vcyc, 9);
    chk("busy_start_sample", int'(vs), 5);

    // Reset while scanning channel 2 (cycles 7..9 at dwell 3).
    run_scan(4'b1111, 4'd3, 4'b1111, 1'b0, 7);
    chk("midrst_sel_before", int'(sel), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel", int'(sel), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sample", int'(sample), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sample_valid) vcnt = vcnt + 1;
    end
    chk("midrst_no_valid", vcnt, 0);

`ifdef SCAN_CONTINUOUS_EN
    // Back-to-back passes every 3 cycles; stop in pass 2 ends after its strobe.
    @(negedge clk); #1;
    stop = 1'b0; en_mask = 4'b0011; dwell = 4'd1; in_vec = 4'b0001; start = 1'b1;
    vcnt = 0; v1 = -1; v2 = -1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        vcnt = vcnt + 1;
        if (vcnt == 1) v1 = c;
        if (vcnt == 2) v2 = c;
      end
      #1;
      if (c == 1) start = 1'b0;
      if (c == 4) stop = 1'b1;
      if (c == 5) stop = 1'b0;
    end
    stop = 1'b1;
    chk("cont_first_strobe", v1, 3);
    chk("cont_second_strobe", v2, 6);
    chk("cont_strobe_count", vcnt, 2);
    chk("cont_sample", int'(sample), 1);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
